hazard_pipe_tracker: RTL and testbench
======================================

HAZARD_PIPE_TRACKER -- requirements
Module: hazard_pipe_tracker

Interface
REQ-001 Parameter: MC_LAT, default 4, number of cycles a multi-cycle op occupies EX; legal range 2..15.
REQ-002 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: id_valid  in  1  ID holds a real instruction.
REQ-005 Port: id_wb_en  in  1  ID instruction writes a register.
REQ-006 Port: id_wb_dest  in  5  ID destination register number.
REQ-007 Port: id_is_load  in  1  ID instruction is a load.
REQ-008 Port: id_mc_op  in  1  ID instruction is multi-cycle (mult/div).
REQ-009 Port: stall_in  in  1  load-use stall request from the data-hazard detector.
REQ-010 Port: flush  in  1  taken branch/jump resolved in ID; squash the fetched instruction.
REQ-011 Port: ex_wb_dest / mem_wb_dest / wb_wb_dest  out  5 each  destination of the instruction in EX / MEM / WB (feeds EX_WBDest, MEM_WBDest).
REQ-012 Port: ex_is_load  out  1  EX holds a load (feeds the load-use check).
REQ-013 Port: pc_we, ifid_we  out  1 each  PC and IF/ID register write enables.
REQ-014 Port: ifid_flush  out  1  clear IF/ID to a bubble.
REQ-015 Port: idex_bubble  out  1  ID/EX receives a bubble this edge.
REQ-016 Port: mc_busy  out  1  multi-cycle op occupying EX.
REQ-017 Port: stall_cycles  out  16  saturating count of cycles with pc_we=0.

Function
REQ-018 Entry encoding: {dest, is_load, mc}; dest = id_wb_dest when id_valid and id_wb_en, else 5'd0; 5'd0 means "no writer"; is_load = id_valid and id_is_load.
REQ-019 FSM states RUN and MC_WAIT; 4-bit down-counter cnt.
REQ-020 RUN, no stall_in, no flush: each edge WB<=MEM, MEM<=EX, EX<=ID entry; pc_we=ifid_we=1, idex_bubble=0.
REQ-021 RUN, stall_in=1: pc_we=ifid_we=0, idex_bubble=1; EX<=bubble (dest 0, is_load 0); MEM/WB still shift.
REQ-022 RUN, flush=1 and stall_in=0: ifid_flush=1, pc_we=ifid_we=1, ID entry advances into EX normally.
REQ-023 RUN, flush=1 and stall_in=1: stall wins; ifid_flush=0, behaviour per REQ-021.
REQ-024 RUN, ID entry with mc=1 advances into EX: next state MC_WAIT, cnt<=MC_LAT-1.
REQ-025 MC_WAIT: EX entry held, MEM<=bubble, WB<=MEM; pc_we=ifid_we=0, idex_bubble=0, ifid_flush=0, mc_busy=1; stall_in and flush ignored.
REQ-026 MC_WAIT: cnt decrements each edge; on the edge where cnt==1, next state RUN; the op therefore occupies EX for exactly MC_LAT cycles.
REQ-027 ex_is_load tracks the EX entry's is_load; 0 for bubbles and while in MC_WAIT (a mc op is never a load).
REQ-028 pc_we, ifid_we, ifid_flush, idex_bubble, mc_busy are combinational from state and inputs; all other outputs registered.
REQ-029 stall_cycles increments by 1 on every edge where pc_we=0; holds at 16'hFFFF.

Reset
REQ-030 rst=1 at an edge: state<=RUN, cnt<=0, EX/MEM/WB entries<=bubble (all dests 0, ex_is_load 0), stall_cycles<=0.
REQ-031 During rst=1, combinational outputs evaluate as RUN with inputs; reset mid-MC_WAIT aborts the op and returns to RUN on that edge.

Verification
REQ-032 Issue dest 8 (wb_en), then dest 9, then non-writer -> after 3 edges ex=0, mem=9, wb=8.
REQ-033 Load to dest 5 enters EX, then stall_in=1 for one cycle -> that cycle pc_we=0, idex_bubble=1; next edge ex_wb_dest=0, mem_wb_dest=5, ex_is_load=0, stall_cycles=1.
REQ-034 MC_LAT=4, mc op dest 3 enters EX -> mc_busy=1 and pc_we=0 for 3 cycles, ex_wb_dest=3 for 4 cycles, mem_wb_dest=0 during wait, then RUN with mem_wb_dest=3.
REQ-035 flush=1 with stall_in=0 -> ifid_flush=1, pc_we=1; flush=1 with stall_in=1 -> ifid_flush=0, pc_we=0.
REQ-036 rst asserted on 2nd wait cycle of a mc op -> next cycle state RUN, all dests 0, mc_busy=0, stall_cycles=0.
REQ-037 Hold stall_in=1 for 70000 cycles -> stall_cycles saturates at 16'hFFFF, no wrap.

Source files
------------

// File: rtl/hazard_pipe_tracker_if.sv
// Handshake bundle between the ID-stage control logic and the hazard pipe tracker.
// master: drives the ID-stage instruction attributes and hazard requests, observes the
//         tracked destinations and pipeline enables.
// slave : the tracker itself; consumes the ID attributes and drives the enables/state.
interface hazard_pipe_tracker_if;
  // ID-stage instruction attributes and hazard requests
  logic        id_valid;
  logic        id_wb_en;
  logic [4:0]  id_wb_dest;
  logic        id_is_load;
  logic        id_mc_op;
  logic        stall_in;
  logic        flush;
  // Tracked pipeline state and enables
  logic [4:0]  ex_wb_dest;
  logic [4:0]  mem_wb_dest;
  logic [4:0]  wb_wb_dest;
  logic        ex_is_load;
  logic        pc_we;
  logic        ifid_we;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        mc_busy;
  logic [15:0] stall_cycles;

  modport master (
    output id_valid, id_wb_en, id_wb_dest, id_is_load, id_mc_op, stall_in, flush,
    input  ex_wb_dest, mem_wb_dest, wb_wb_dest, ex_is_load, pc_we, ifid_we, ifid_flush,
           idex_bubble, mc_busy, stall_cycles
  );

  modport slave (
    input  id_valid, id_wb_en, id_wb_dest, id_is_load, id_mc_op, stall_in, flush,
    output ex_wb_dest, mem_wb_dest, wb_wb_dest, ex_is_load, pc_we, ifid_we, ifid_flush,
           idex_bubble, mc_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_pipe_tracker.sv
// Tracks the destination register and load flag of the instructions in EX/MEM/WB of a
// 5-stage pipeline, and generates PC / IF/ID / ID/EX control for load-use stalls,
// branch flushes and multi-cycle (mult/div) ops that occupy EX for MC_LAT cycles.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - hazard_pipe_tracker_if.slave: ID attributes, stall_in/flush in; tracked
//         destinations, ex_is_load, pc_we/ifid_we/ifid_flush/idex_bubble/mc_busy and the
//         saturating stall_cycles counter out.
module hazard_pipe_tracker #(
  parameter int unsigned MC_LAT = 4  // legal range 2..15
) (
  input logic                   clk,
  input logic                   rst,
  hazard_pipe_tracker_if.slave  bus
);

  typedef enum logic [0:0] {StRun, StMcWait} state_e;

  localparam logic [3:0] LatM1 = 4'(MC_LAT - 1);

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic [4:0]  r_ex_dest;
  logic [4:0]  r_mem_dest;
  logic [4:0]  r_wb_dest;
  logic        r_ex_load;
  logic [15:0] r_stall_cycles;

  logic        w_run;
  logic        w_pc_we;
  logic [4:0]  w_id_dest;
  logic        w_id_mc;
  logic        w_id_load;

  // Reset forces the combinational controls to evaluate as if in RUN.
  assign w_run     = rst | (r_state == StRun);
  assign w_pc_we   = w_run & ~bus.stall_in;

  // ID entry encoding; dest 0 means "no writer".
  assign w_id_dest = (bus.id_valid & bus.id_wb_en) ? bus.id_wb_dest : 5'd0;
  assign w_id_mc   = bus.id_valid & bus.id_mc_op;
  // A multi-cycle op is never treated as a load.
  assign w_id_load = bus.id_valid & bus.id_is_load & ~w_id_mc;

  assign bus.pc_we        = w_pc_we;
  assign bus.ifid_we      = w_pc_we;
  assign bus.ifid_flush   = w_run & bus.flush & ~bus.stall_in;
  assign bus.idex_bubble  = w_run & bus.stall_in;
  assign bus.mc_busy      = ~w_run;
  assign bus.ex_wb_dest   = r_ex_dest;
  assign bus.mem_wb_dest  = r_mem_dest;
  assign bus.wb_wb_dest   = r_wb_dest;
  assign bus.ex_is_load   = r_ex_load;
  assign bus.stall_cycles = r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= StRun;
      r_cnt          <= 4'd0;
      r_ex_dest      <= 5'd0;
      r_mem_dest     <= 5'd0;
      r_wb_dest      <= 5'd0;
      r_ex_load      <= 1'b0;
      r_stall_cycles <= 16'd0;
    end else begin
      if (!w_pc_we && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
      unique case (r_state)
        StRun: begin
          r_wb_dest  <= r_mem_dest;
          r_mem_dest <= r_ex_dest;
          if (bus.stall_in) begin
            // Load-use stall: bubble into EX, ID/IF hold; flush is suppressed.
            r_ex_dest <= 5'd0;
            r_ex_load <= 1'b0;
          end else begin
            r_ex_dest <= w_id_dest;
            r_ex_load <= w_id_load;
            if (w_id_mc) begin
              r_state <= StMcWait;
              r_cnt   <= LatM1;
            end
          end
        end
        StMcWait: begin
          // EX entry held; bubbles drain into MEM behind it.
          r_wb_dest  <= r_mem_dest;
          r_mem_dest <= 5'd0;
          r_cnt      <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= StRun;
          end
        end
        default: r_state <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
module tb_hazard_pipe_tracker;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  hazard_pipe_tracker_if bus ();

  hazard_pipe_tracker #(.MC_LAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic we, input logic [4:0] d,
                        input logic ld, input logic mc);
    bus.id_valid   = v;
    bus.id_wb_en   = we;
    bus.id_wb_dest = d;
    bus.id_is_load = ld;
    bus.id_mc_op   = mc;
  endtask

  initial begin
    rst = 1'b1;
    set_id(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    bus.stall_in = 1'b0;
    bus.flush    = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_ex", 32'(bus.ex_wb_dest), 32'd0);
    chk("rst_mem", 32'(bus.mem_wb_dest), 32'd0);
    chk("rst_wb", 32'(bus.wb_wb_dest), 32'd0);
    chk("rst_stall_cycles", 32'(bus.stall_cycles), 32'd0);
    chk("rst_mc_busy", 32'(bus.mc_busy), 32'd0);
    chk("rst_pc_we", 32'(bus.pc_we), 32'd1);

    // Shift: dest 8, dest 9, non-writer
    set_id(1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
    step();
    chk("shift1_ex", 32'(bus.ex_wb_dest), 32'd8);
    set_id(1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    step();
    chk("shift2_ex", 32'(bus.ex_wb_dest), 32'd9);
    chk("shift2_mem", 32'(bus.mem_wb_dest), 32'd8);
    set_id(1'b1, 1'b0, 5'd7, 1'b0, 1'b0);
    step();
    chk("shift3_ex", 32'(bus.ex_wb_dest), 32'd0);
    chk("shift3_mem", 32'(bus.mem_wb_dest), 32'd9);
    chk("shift3_wb", 32'(bus.wb_wb_dest), 32'd8);
    // Invalid instruction with wb_en set is not a writer
    set_id(1'b0, 1'b1, 5'd12, 1'b1, 1'b0);
    step();
    chk("invalid_ex", 32'(bus.ex_wb_dest), 32'd0);
    chk("invalid_ld", 32'(bus.ex_is_load), 32'd0);

    // Load-use stall
    set_id(1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    chk("load_ex", 32'(bus.ex_wb_dest), 32'd5);
    chk("load_is_load", 32'(bus.ex_is_load), 32'd1);
    set_id(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    bus.stall_in = 1'b1;
    #1;
    chk("stall_pc_we", 32'(bus.pc_we), 32'd0);
    chk("stall_ifid_we", 32'(bus.ifid_we), 32'd0);
    chk("stall_bubble", 32'(bus.idex_bubble), 32'd1);
    step();
    bus.stall_in = 1'b0;
    chk("stall_ex", 32'(bus.ex_wb_dest), 32'd0);
    chk("stall_mem", 32'(bus.mem_wb_dest), 32'd5);
    chk("stall_is_load", 32'(bus.ex_is_load), 32'd0);
    chk("stall_cnt1", 32'(bus.stall_cycles), 32'd1);

    // Flush without and with stall
    set_id(1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
    bus.flush = 1'b1;
    #1;
    chk("flush_ifid_flush", 32'(bus.ifid_flush), 32'd1);
    chk("flush_pc_we", 32'(bus.pc_we), 32'd1);
    chk("flush_bubble", 32'(bus.idex_bubble), 32'd0);
    step();
    chk("flush_ex", 32'(bus.ex_wb_dest), 32'd6);
    bus.stall_in = 1'b1;
    #1;
    chk("flushstall_ifid_flush", 32'(bus.ifid_flush), 32'd0);
    chk("flushstall_pc_we", 32'(bus.pc_we), 32'd0);
    step();
    bus.stall_in = 1'b0;
    bus.flush    = 1'b0;
    chk("flushstall_ex", 32'(bus.ex_wb_dest), 32'd0);
    chk("flushstall_mem", 32'(bus.mem_wb_dest), 32'd6);
    chk("flushstall_cnt", 32'(bus.stall_cycles), 32'd2);

    // Drain pipeline
    set_id(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    step();
    chk("drain_wb", 32'(bus.wb_wb_dest), 32'd0);

    // Multi-cycle op, MC_LAT=4
    set_id(1'b1, 1'b1, 5'd3, 1'b0, 1'b1);
    step();
    set_id(1'b1, 1'b1, 5'd10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        bus.stall_in = 1'b1;
        bus.flush    = 1'b1;
        #1;
        chk("mc_ign_bubble", 32'(bus.idex_bubble), 32'd0);
        chk("mc_ign_flush", 32'(bus.ifid_flush), 32'd0);
        bus.stall_in = 1'b0;
        bus.flush    = 1'b0;
      end
      chk($sformatf("mc_busy_%0d", i), 32'(bus.mc_busy), 32'd1);
      chk($sformatf("mc_pc_we_%0d", i), 32'(bus.pc_we), 32'd0);
      chk($sformatf("mc_ex_%0d", i), 32'(bus.ex_wb_dest), 32'd3);
      chk($sformatf("mc_mem_%0d", i), 32'(bus.mem_wb_dest), 32'd0);
      chk($sformatf("mc_is_load_%0d", i), 32'(bus.ex_is_load), 32'd0);
      step();
    end
    chk("mc_end_busy", 32'(bus.mc_busy), 32'd0);
    chk("mc_end_pc_we", 32'(bus.pc_we), 32'd1);
    chk("mc_end_ex", 32'(bus.ex_wb_dest), 32'd3);
    chk("mc_end_cnt", 32'(bus.stall_cycles), 32'd5);
    step();
    chk("mc_after_ex", 32'(bus.ex_wb_dest), 32'd10);
    chk("mc_after_mem", 32'(bus.mem_wb_dest), 32'd3);

    // Reset during second wait cycle of a mc op
    set_id(1'b1, 1'b1, 5'd4, 1'b0, 1'b1);
    step();
    set_id(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    chk("rstmc_busy_before", 32'(bus.mc_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmc_busy_during", 32'(bus.mc_busy), 32'd0);
    chk("rstmc_pc_we_during", 32'(bus.pc_we), 32'd1);
    step();
    rst = 1'b0;
    #1;
    chk("rstmc_ex", 32'(bus.ex_wb_dest), 32'd0);
    chk("rstmc_mem", 32'(bus.mem_wb_dest), 32'd0);
    chk("rstmc_wb", 32'(bus.wb_wb_dest), 32'd0);
    chk("rstmc_busy", 32'(bus.mc_busy), 32'd0);
    chk("rstmc_cnt", 32'(bus.stall_cycles), 32'd0);
    chk("rstmc_pc_we", 32'(bus.pc_we), 32'd1);

    // Saturation of stall_cycles
    bus.stall_in = 1'b1;
    for (int i = 0; i < 65534; i++) step();
    chk("sat_pre", 32'(bus.stall_cycles), 32'hFFFE);
    step();
    chk("sat_hit", 32'(bus.stall_cycles), 32'hFFFF);
    for (int i = 0; i < 4465; i++) step();
    chk("sat_hold", 32'(bus.stall_cycles), 32'hFFFF);
    bus.stall_in = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
